// File: rtl/fault_pkg.sv
// rtl/fault_pkg.sv - shared encodings for the fault-injecting gate
package fault_pkg;

  localparam int FUNC_OR  = 0;
  localparam int FUNC_AND = 1;
  localparam int FUNC_XOR = 2;
  localparam int FUNC_NOR = 3;

  typedef enum logic [1:0] {
    FT_STUCK0 = 2'b00,
    FT_STUCK1 = 2'b01,
    FT_INVERT = 2'b10,
    FT_CANCEL = 2'b11
  } fault_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } sched_state_e;

  function automatic logic apply_fault(input logic v, input fault_type_e t);
    case (t)
      FT_STUCK0: apply_fault = 1'b0;
      FT_STUCK1: apply_fault = 1'b1;
      FT_INVERT: apply_fault = ~v;
      default:   apply_fault = v;
    endcase
  endfunction

endpackage

// File: rtl/fault_sched.sv
// rtl/fault_sched.sv - fault request acceptance, delay and duration scheduling
module fault_sched
  import fault_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(N+1)-1:0]   cfg_pin,
  input  logic [1:0]               cfg_type,
  input  logic [CW-1:0]            cfg_delay,
  input  logic [CW-1:0]            cfg_dur,
  output logic [$clog2(N+1)-1:0]   inj_pin,
  output fault_type_e              inj_type,
  output logic                     fault_armed,
  output logic                     fault_active,
  output logic                     cfg_err
);

  localparam int PW = $clog2(N+1);
  localparam logic [PW-1:0] PIN_Y = PW'(N);

  sched_state_e    state_q, state_d;
  logic [CW-1:0]   delay_q, delay_d;
  logic [CW-1:0]   dur_q, dur_d;
  logic            perm_q, perm_d;
  logic [PW-1:0]   pin_q, pin_d;
  fault_type_e     type_q, type_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    dur_d   = dur_q;
    perm_d  = perm_q;
    pin_d   = pin_q;
    type_d  = type_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      delay_d = '0;
      dur_d   = '0;
      perm_d  = 1'b0;
      pin_d   = '0;
      type_d  = FT_CANCEL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            // Out-of-range pins are consumed but flagged; cancels are consumed silently.
            if (cfg_pin > PIN_Y) begin
              err_d = 1'b1;
            end else if (fault_type_e'(cfg_type) != FT_CANCEL) begin
              pin_d  = cfg_pin;
              type_d = fault_type_e'(cfg_type);
              dur_d  = cfg_dur;
              perm_d = (cfg_dur == '0);
              if (cfg_delay == '0) begin
                state_d = ST_ACTIVE;
              end else begin
                state_d = ST_ARMED;
                delay_d = cfg_delay;
              end
            end
          end
        end
        ST_ARMED: begin
          if (delay_q == CW'(1)) begin
            state_d = ST_ACTIVE;
            delay_d = '0;
          end else begin
            delay_d = delay_q - CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (!perm_q) begin
            if (dur_q == CW'(1)) begin
              state_d = ST_IDLE;
              dur_d   = '0;
              type_d  = FT_CANCEL;
            end else begin
              dur_d = dur_q - CW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      dur_q   <= '0;
      perm_q  <= 1'b0;
      pin_q   <= '0;
      type_q  <= FT_CANCEL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      dur_q   <= dur_d;
      perm_q  <= perm_d;
      pin_q   <= pin_d;
      type_q  <= type_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready    = (state_q == ST_IDLE);
  assign fault_armed  = (state_q == ST_ARMED);
  assign fault_active = (state_q == ST_ACTIVE);
  assign cfg_err      = err_q;
  assign inj_pin      = pin_q;
  assign inj_type     = type_q;

endmodule

// File: rtl/fault_gate_n.sv
// rtl/fault_gate_n.sv - N-input gate with scheduled stuck-at/invert fault injection
module fault_gate_n
  import fault_pkg::*;
#(
  parameter int N    = 3,
  parameter int FUNC = 0,
  parameter int CW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             a,
  output logic                     y,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(N+1)-1:0]   cfg_pin,
  input  logic [1:0]               cfg_type,
  input  logic [CW-1:0]            cfg_delay,
  input  logic [CW-1:0]            cfg_dur,
  input  logic                     clear,
  output logic                     fault_armed,
  output logic                     fault_active,
  output logic                     cfg_err,
  output logic [CW-1:0]            hit_count
);

  localparam int PW = $clog2(N+1);
  localparam logic [PW-1:0] PIN_Y = PW'(N);

  logic [PW-1:0] inj_pin;
  fault_type_e   inj_type;
  logic [N-1:0]  a_inj;
  logic          gate_out;
  logic          y_ref;
  logic [CW-1:0] hit_q;

  function automatic logic gate_reduce(input logic [N-1:0] v);
    case (FUNC)
      FUNC_OR:  gate_reduce = |v;
      FUNC_AND: gate_reduce = &v;
      FUNC_XOR: gate_reduce = ^v;
      FUNC_NOR: gate_reduce = ~|v;
      default:  gate_reduce = |v;
    endcase
  endfunction

  fault_sched #(
    .N  (N),
    .CW (CW)
  ) u_sched (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pin      (cfg_pin),
    .cfg_type     (cfg_type),
    .cfg_delay    (cfg_delay),
    .cfg_dur      (cfg_dur),
    .inj_pin      (inj_pin),
    .inj_type     (inj_type),
    .fault_armed  (fault_armed),
    .fault_active (fault_active),
    .cfg_err      (cfg_err)
  );

  // Input-pin faults land ahead of the reduction so they interact with the other inputs.
  for (genvar i = 0; i < N; i++) begin : g_pin
    assign a_inj[i] = (fault_active && (inj_pin == PW'(i))) ? apply_fault(a[i], inj_type) : a[i];
  end

  assign gate_out = gate_reduce(a_inj);
  assign y_ref    = gate_reduce(a);
  assign y        = (fault_active && (inj_pin == PIN_Y)) ? apply_fault(gate_out, inj_type) : gate_out;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hit_q <= '0;
    end else if (fault_active && (y != y_ref) && (hit_q != {CW{1'b1}})) begin
      hit_q <= hit_q + CW'(1);
    end
  end

  assign hit_count = hit_q;

endmodule

// File: tb/tb_fault_gate_n.sv
// tb/tb_fault_gate_n.sv - directed vector bench for fault_gate_n
module tb_fault_gate_n;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  // OR, N=3, CW=16
  logic [2:0]  o_a;   logic o_y, o_valid, o_ready, o_armed, o_active, o_err;
  logic [1:0]  o_pin; logic [1:0] o_type; logic [15:0] o_delay, o_dur, o_hit;
  // AND, N=4, CW=4
  logic [3:0]  n_a;   logic n_y, n_valid, n_ready, n_armed, n_active, n_err;
  logic [2:0]  n_pin; logic [1:0] n_type; logic [3:0] n_delay, n_dur, n_hit;
  // XOR, N=3, CW=16
  logic [2:0]  x_a;   logic x_y, x_valid, x_ready, x_armed, x_active, x_err;
  logic [1:0]  x_pin; logic [1:0] x_type; logic [15:0] x_delay, x_dur, x_hit;
  // NOR, N=2, config tied off
  logic [1:0]  r_a;   logic r_y, r_ready, r_armed, r_active, r_err;
  logic [15:0] r_hit;

  fault_gate_n #(.N(3), .FUNC(0), .CW(16)) u_or (
    .clk(clk), .rst(rst), .a(o_a), .y(o_y), .cfg_valid(o_valid), .cfg_ready(o_ready),
    .cfg_pin(o_pin), .cfg_type(o_type), .cfg_delay(o_delay), .cfg_dur(o_dur), .clear(clear),
    .fault_armed(o_armed), .fault_active(o_active), .cfg_err(o_err), .hit_count(o_hit));

  fault_gate_n #(.N(4), .FUNC(1), .CW(4)) u_and (
    .clk(clk), .rst(rst), .a(n_a), .y(n_y), .cfg_valid(n_valid), .cfg_ready(n_ready),
    .cfg_pin(n_pin), .cfg_type(n_type), .cfg_delay(n_delay), .cfg_dur(n_dur), .clear(clear),
    .fault_armed(n_armed), .fault_active(n_active), .cfg_err(n_err), .hit_count(n_hit));

  fault_gate_n #(.N(3), .FUNC(2), .CW(16)) u_xor (
    .clk(clk), .rst(rst), .a(x_a), .y(x_y), .cfg_valid(x_valid), .cfg_ready(x_ready),
    .cfg_pin(x_pin), .cfg_type(x_type), .cfg_delay(x_delay), .cfg_dur(x_dur), .clear(clear),
    .fault_armed(x_armed), .fault_active(x_active), .cfg_err(x_err), .hit_count(x_hit));

  fault_gate_n #(.N(2), .FUNC(3), .CW(16)) u_nor (
    .clk(clk), .rst(rst), .a(r_a), .y(r_y), .cfg_valid(1'b0), .cfg_ready(r_ready),
    .cfg_pin(2'd0), .cfg_type(2'd0), .cfg_delay(16'd0), .cfg_dur(16'd0), .clear(clear),
    .fault_armed(r_armed), .fault_active(r_active), .cfg_err(r_err), .hit_count(r_hit));

  typedef struct {
    logic [3:0] a;
    logic       exp_or;
    logic       exp_and;
    logic       exp_xor;
    logic       exp_nor;
  } gate_vec_t;

  gate_vec_t vecs[8];
  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; clear = 1'b0;
    o_a = '0; o_valid = 0; o_pin = '0; o_type = '0; o_delay = '0; o_dur = '0;
    n_a = '0; n_valid = 0; n_pin = '0; n_type = '0; n_delay = '0; n_dur = '0;
    x_a = '0; x_valid = 0; x_pin = '0; x_type = '0; x_delay = '0; x_dur = '0;
    r_a = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("rst_ready_or", o_ready, 1);
    check("rst_ready_and", n_ready, 1);
    check("rst_armed_and", n_armed, 0);
    check("rst_active_and", n_active, 0);
    check("rst_err_and", n_err, 0);
    check("rst_hit_or", o_hit, 0);

    // Fault-free gate functions
    for (int i = 0; i < 8; i++) begin
      o_a = vecs[i].a[2:0];
      n_a = vecs[i].a;
      x_a = vecs[i].a[2:0];
      r_a = vecs[i].a[1:0];
      #1;
      check($sformatf("or_vec%0d", i),  o_y, vecs[i].exp_or);
      check($sformatf("and_vec%0d", i), n_y, vecs[i].exp_and);
      check($sformatf("xor_vec%0d", i), x_y, vecs[i].exp_xor);
      check($sformatf("nor_vec%0d", i), r_y, vecs[i].exp_nor);
    end
    step();

    // OR: stuck-1 on output pin, no delay, 4 cycles
    o_a = 3'b000; o_pin = 2'd3; o_type = 2'b01; o_delay = 16'd0; o_dur = 16'd4; o_valid = 1;
    #1 check("or_pre_y", o_y, 0);
    step();
    o_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("or_y_c%0d", k), o_y, (k <= 4) ? 1 : 0);
      check($sformatf("or_act_c%0d", k), o_active, (k <= 4) ? 1 : 0);
      step();
    end
    check("or_hit", o_hit, 4);

    // XOR: invert pin 0 for 3 cycles while a changes
    x_a = 3'b001; x_pin = 2'd0; x_type = 2'b10; x_delay = 16'd0; x_dur = 16'd3; x_valid = 1;
    step();
    x_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      logic [2:0] pat;
      pat = 3'(k * 5);
      x_a = pat;
      #1;
      check($sformatf("xor_inv_c%0d", k), x_y, (^pat) ^ (k <= 3));
      step();
    end
    check("xor_hit", x_hit, 3);

    // AND: stuck-0 on a[2], delay 5, permanent
    n_a = 4'hF; n_pin = 3'd2; n_type = 2'b00; n_delay = 4'd5; n_dur = 4'd0; n_valid = 1;
    step();
    n_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("and_armed_c%0d", k), n_armed, (k <= 5) ? 1 : 0);
      check($sformatf("and_y_c%0d", k), n_y, (k <= 5) ? 1 : 0);
      step();
    end
    check("and_hit3", n_hit, 3);
    repeat (20) step();
    check("and_hit_sat", n_hit, 15);
    check("and_perm_active", n_active, 1);

    // Requests while ACTIVE are not taken
    n_pin = 3'd3; n_type = 2'b01; n_delay = 4'd0; n_dur = 4'd0; n_valid = 1;
    #1 check("and_busy_ready", n_ready, 0);
    step();
    check("and_busy_active", n_active, 1);
    check("and_busy_y", n_y, 0);
    clear = 1;
    step();
    clear = 0; n_valid = 0;
    #1;
    check("and_clr_active", n_active, 0);
    check("and_clr_y", n_y, 1);
    check("and_clr_hit", n_hit, 0);
    check("and_clr_ready", n_ready, 1);

    // clear beats an IDLE accept
    clear = 1; n_valid = 1; n_pin = 3'd0; n_type = 2'b00; n_delay = 4'd0; n_dur = 4'd0;
    step();
    clear = 0; n_valid = 0;
    #1;
    check("clr_acc_active", n_active, 0);
    check("clr_acc_armed", n_armed, 0);
    check("clr_acc_y", n_y, 1);

    // Out-of-range pin
    n_pin = 3'd5; n_type = 2'b01; n_valid = 1;
    step();
    n_valid = 0;
    #1;
    check("bad_pin_err", n_err, 1);
    check("bad_pin_ready", n_ready, 1);
    check("bad_pin_active", n_active, 0);
    check("bad_pin_armed", n_armed, 0);
    step();
    check("bad_pin_err_drop", n_err, 0);

    // Cancel
    n_pin = 3'd1; n_type = 2'b11; n_valid = 1;
    step();
    n_valid = 0;
    #1;
    check("cancel_active", n_active, 0);
    check("cancel_armed", n_armed, 0);
    check("cancel_err", n_err, 0);
    check("cancel_y", n_y, 1);

    // Invert on output pin, delay 2, duration 2
    n_pin = 3'd4; n_type = 2'b10; n_delay = 4'd2; n_dur = 4'd2; n_valid = 1;
    step();
    n_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("dly_y_c%0d", k), n_y, (k == 3 || k == 4) ? 0 : 1);
      check($sformatf("dly_act_c%0d", k), n_active, (k == 3 || k == 4) ? 1 : 0);
      step();
    end

    // rst mid-ARMED with counter at 3
    n_pin = 3'd0; n_type = 2'b00; n_delay = 4'd5; n_dur = 4'd2; n_valid = 1;
    step();
    n_valid = 0;
    step();
    step();
    check("pre_rst_armed", n_armed, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("rst_mid_armed", n_armed, 0);
    check("rst_mid_active", n_active, 0);
    check("rst_mid_ready", n_ready, 1);
    check("rst_mid_y", n_y, 1);
    check("rst_mid_hit", n_hit, 0);
    repeat (6) step();
    check("rst_mid_late_active", n_active, 0);
    check("rst_mid_late_y", n_y, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fault_gate_n.md
FAULT_GATE_N -- requirements
Module: fault_gate_n

Interface
REQ-001 The block SHALL have parameter N, default 3, setting the gate input count (legal 2..16).
REQ-002 The block SHALL have parameter FUNC, default 0, selecting the gate function: 0 OR, 1 AND, 2 XOR, 3 NOR.
REQ-003 The block SHALL have parameter CW, default 16, setting the counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port a, input, N bits, the gate data inputs.
REQ-007 The block SHALL have port y, output, 1 bit, the gate output after fault injection.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit, fault request valid.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit, request acceptable.
REQ-010 The block SHALL have port cfg_pin, input, $clog2(N+1) bits, target pin: 0..N-1 is a[i], N is y.
REQ-011 The block SHALL have port cfg_type, input, 2 bits, fault type: 00 stuck-0, 01 stuck-1, 10 invert, 11 cancel.
REQ-012 The block SHALL have port cfg_delay, input, CW bits, cycles from accept to activation.
REQ-013 The block SHALL have port cfg_dur, input, CW bits, active cycles; 0 means permanent.
REQ-014 The block SHALL have port clear, input, 1 bit, abort any fault and zero hit_count.
REQ-015 The block SHALL have outputs fault_armed (1 bit), fault_active (1 bit), cfg_err (1-bit pulse), and hit_count (CW bits).

Function
REQ-016 y SHALL be combinational from a and the registered fault state, with zero-cycle latency.
REQ-017 With no fault active, y SHALL equal the FUNC reduction of a.
REQ-018 FSM states SHALL be IDLE, ARMED and ACTIVE; cfg_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when cfg_valid and cfg_ready are both 1 on a clk edge; the block SHALL latch pin, type and dur.
REQ-020 On accept with delay=0, the FSM SHALL enter ACTIVE.
REQ-021 On accept with delay>0, the FSM SHALL enter ARMED with the counter loaded to delay, decrement once per cycle, and enter ACTIVE on the edge where the counter is 1.
REQ-022 The fault SHALL first affect y in cycle delay+1 after the accept edge.
REQ-023 In ACTIVE with dur>0, the fault SHALL be applied for exactly dur cycles and the FSM SHALL then return to IDLE; with dur=0 it SHALL stay ACTIVE until clear or rst.
REQ-024 Injection on pin i<N SHALL replace a[i] before the gate function; injection on pin N SHALL replace the gate result.
REQ-025 An accepted cancel (11) SHALL leave the FSM in IDLE with no effect.
REQ-026 An accepted request with cfg_pin>N SHALL be dropped, leave the FSM in IDLE, and pulse cfg_err high for 1 cycle.
REQ-027 hit_count SHALL increment in each ACTIVE cycle where y differs from the fault-free result, and SHALL saturate at 2^CW-1.
REQ-028 clear SHALL take priority over cfg accept: the next state is IDLE, the injection is removed and hit_count is set to 0.
REQ-029 fault_armed SHALL equal (state==ARMED) and fault_active SHALL equal (state==ACTIVE), both registered.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL set state to IDLE, counters to 0, hit_count to 0, cfg_err to 0 and the injection fields to none.
REQ-031 rst SHALL override clear and cfg_valid, including mid-ARMED and mid-ACTIVE.
REQ-032 After reset, cfg_ready SHALL read 1 and y SHALL be fault-free.

Structure
REQ-033 A shared package fault_pkg SHALL hold the fault-type encodings, the FUNC encodings and the FSM state enum.
REQ-034 The block SHALL have one sub-module, fault_sched, containing the FSM plus the delay and duration counters; gate and injection muxing SHALL stay in the top level.

Verification
REQ-035 With N=3, FUNC=OR, a=000, request pin=3, type=01, delay=0, dur=4 -> y=1 for exactly 4 cycles starting 1 cycle after accept, and hit_count=4.
REQ-036 With N=4, FUNC=AND, a=1111, request pin=2, type=00, delay=5, dur=0 -> fault_armed for 5 cycles, then y=0 held until clear; clear -> y=1 and hit_count=0 next cycle.
REQ-037 With FUNC=XOR, request type=10 on pin 0, dur=3 while a toggles -> y is the inverse of the fault-free result for 3 cycles.
REQ-038 A request with cfg_pin=N+1 -> one-cycle cfg_err, FSM stays IDLE; a cancel request -> no state change.
REQ-039 cfg_valid held high during ACTIVE -> cfg_ready=0 and no accept; clear and cfg_valid in the same cycle -> IDLE with no accept.
REQ-040 rst asserted mid-ARMED (counter=3) -> IDLE and outputs at reset values next cycle; with CW=4 and a permanent stuck fault against the data, hit_count saturates at 15.
